hazard_ctrl: RTL and testbench

- Central hazard and flush controller for the 5-stage RV32I pipeline.
- Produces the `stall` and `jb` inputs consumed by the D/E pipeline registers, plus F/D hold, whole-pipe freeze and rs1/rs2 forwarding selects.
- Tracks destination-register metadata for E, M and W in internal shadow registers, so it needs only D-stage decode fields and E/M status as inputs.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/hazard_ctrl_if.sv | 34 +++
 rtl/fwd_sel.sv | 24 ++
 rtl/hazard_ctrl.sv | 99 +++++++++
 tb/tb_hazard_ctrl.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline types for the hazard controller: per-stage destination metadata,
// forwarding-select encodings and the bubble record.
package cpu_pkg;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic       is_load;
    logic       is_mem;
  } stage_info_t;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_M  = 2'd1;
  localparam logic [1:0] FWD_W  = 2'd2;

  localparam stage_info_t BUBBLE = '0;

  // x0 is hard-wired zero, so a write to it is never a forwarding source.
  function automatic logic writes_reg(input stage_info_t s, input logic [4:0] idx);
    return s.valid && s.we && (s.rd == idx) && (idx != 5'd0);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// D-stage decode fields and E/M status into the hazard controller, pipeline control
// back out. The pipeline side drives through master; the controller uses slave.
interface hazard_ctrl_if;
  logic       D_valid;
  logic [4:0] D_rs1_index;
  logic [4:0] D_rs2_index;
  logic       D_rs1_used;
  logic       D_rs2_used;
  logic [4:0] D_rd_index;
  logic       D_rd_we;
  logic       D_is_load;
  logic       D_is_mem;
  logic       E_jb;
  logic       dmem_ready;

  logic       stall;
  logic       jb;
  logic       freeze;
  logic [1:0] fwd_rs1_sel;
  logic [1:0] fwd_rs2_sel;
  logic       mem_timeout;

  modport master (
    output D_valid, D_rs1_index, D_rs2_index, D_rs1_used, D_rs2_used,
           D_rd_index, D_rd_we, D_is_load, D_is_mem, E_jb, dmem_ready,
    input  stall, jb, freeze, fwd_rs1_sel, fwd_rs2_sel, mem_timeout
  );

  modport slave (
    input  D_valid, D_rs1_index, D_rs2_index, D_rs1_used, D_rs2_used,
           D_rd_index, D_rd_we, D_is_load, D_is_mem, E_jb, dmem_ready,
    output stall, jb, freeze, fwd_rs1_sel, fwd_rs2_sel, mem_timeout
  );
endinterface

// File: rtl/fwd_sel.sv
// Forwarding select for one source operand; purely combinational, M beats W,
// loads in M cannot forward because their data is not ready yet.
module fwd_sel
  import cpu_pkg::*;
(
  input  logic [4:0]  src_i,
  input  stage_info_t m_i,
  input  stage_info_t w_i,
  output logic [1:0]  sel_o
);

  logic unused_fields;
  assign unused_fields = m_i.is_mem ^ w_i.is_load ^ w_i.is_mem;

  always_comb begin
    sel_o = FWD_RF;
    if (writes_reg(m_i, src_i) && !m_i.is_load) begin
      sel_o = FWD_M;
    end else if (writes_reg(w_i, src_i)) begin
      sel_o = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/flush controller: all outputs combinational from E/M/W shadows and inputs (0 latency);
// a stalled dmem access freezes every shadow, with a sticky timeout after WAIT_MAX frozen cycles.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 4
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
);

  stage_info_t e_q, e_d;
  stage_info_t m_q, m_d;
  stage_info_t w_q, w_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  logic freeze;
  logic load_use;
  logic flush;
  logic stall;

  always_comb begin
    freeze = m_q.valid && m_q.is_mem && !hz.dmem_ready;

    load_use = e_q.valid && e_q.is_load && e_q.we && (e_q.rd != 5'd0) && hz.D_valid &&
               ((hz.D_rs1_used && (hz.D_rs1_index == e_q.rd)) ||
                (hz.D_rs2_used && (hz.D_rs2_index == e_q.rd)));

    // Priority freeze > flush > stall; a masked event is simply seen again next cycle.
    flush = !freeze && hz.E_jb;
    stall = !freeze && !hz.E_jb && load_use;
  end

  always_comb begin
    cnt_d = '0;
    if (freeze) begin
      cnt_d = (cnt_q == CNT_W'(WAIT_MAX)) ? cnt_q : cnt_q + CNT_W'(1);
    end
    timeout_d = timeout_q || (freeze && (cnt_d == CNT_W'(WAIT_MAX)));
  end

  always_comb begin
    e_d = e_q;
    m_d = m_q;
    w_d = w_q;
    if (!freeze) begin
      w_d = m_q;
      m_d = e_q;
      if (flush || stall) begin
        e_d = BUBBLE;
      end else begin
        e_d.valid   = hz.D_valid;
        e_d.rd      = hz.D_rd_index;
        e_d.we      = hz.D_rd_we;
        e_d.is_load = hz.D_is_load;
        e_d.is_mem  = hz.D_is_mem;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_q       <= BUBBLE;
      m_q       <= BUBBLE;
      w_q       <= BUBBLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      e_q       <= e_d;
      m_q       <= m_d;
      w_q       <= w_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  fwd_sel u_fwd_rs1 (
    .src_i (hz.D_rs1_index),
    .m_i   (m_q),
    .w_i   (w_q),
    .sel_o (hz.fwd_rs1_sel)
  );

  fwd_sel u_fwd_rs2 (
    .src_i (hz.D_rs2_index),
    .m_i   (m_q),
    .w_i   (w_q),
    .sel_o (hz.fwd_rs2_sel)
  );

  assign hz.stall       = stall;
  assign hz.jb          = flush;
  assign hz.freeze      = freeze;
  assign hz.mem_timeout = timeout_d;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a per-cycle vector table for hazards and forwarding,
// then hand-written sequences for memory wait, timeout and reset.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if hz ();

  hazard_ctrl #(
    .WAIT_MAX (15),
    .CNT_W    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  typedef struct packed {
    logic       dv;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       mem;
  } ins_t;

  typedef struct {
    ins_t       d;
    logic       ejb;
    logic       st;
    logic       fl;
    logic [1:0] f1;
    logic [1:0] f2;
  } vec_t;

  int errors = 0;
  int checks = 0;
  vec_t tbl[$];
  ins_t nop;
  ins_t dep;

  function automatic ins_t mk(input logic dv, input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                              input logic we, input logic ld, input logic mem);
    ins_t r;
    r.dv = dv; r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2;
    r.rd = rd; r.we = we; r.ld = ld; r.mem = mem;
    return r;
  endfunction

  function automatic vec_t vv(input ins_t d, input logic ejb, input logic st, input logic fl,
                              input logic [1:0] f1, input logic [1:0] f2);
    vec_t v;
    v.d = d; v.ejb = ejb; v.st = st; v.fl = fl; v.f1 = f1; v.f2 = f2;
    return v;
  endfunction

  task automatic drive(input ins_t d, input logic ejb, input logic rdy, input logic r);
    hz.D_valid     = d.dv;
    hz.D_rs1_index = d.rs1;
    hz.D_rs1_used  = d.u1;
    hz.D_rs2_index = d.rs2;
    hz.D_rs2_used  = d.u2;
    hz.D_rd_index  = d.rd;
    hz.D_rd_we     = d.we;
    hz.D_is_load   = d.ld;
    hz.D_is_mem    = d.mem;
    hz.E_jb        = ejb;
    hz.dmem_ready  = rdy;
    rst            = r;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later, far from the rising edge.
  task automatic cyc(input ins_t d, input logic ejb, input logic rdy, input logic r);
    @(negedge clk);
    drive(d, ejb, rdy, r);
    #1;
  endtask

  task automatic chk1(input string tag, input int id, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @step %0d: got %0d, expected %0d", tag, id, act, exp);
    end
  endtask

  task automatic chk_all(input int id, input logic st, input logic fl, input logic frz,
                         input logic [1:0] f1, input logic [1:0] f2, input logic to);
    chk1("stall",       id, {1'b0, hz.stall},       {1'b0, st});
    chk1("jb",          id, {1'b0, hz.jb},          {1'b0, fl});
    chk1("freeze",      id, {1'b0, hz.freeze},      {1'b0, frz});
    chk1("fwd_rs1_sel", id, hz.fwd_rs1_sel,         f1);
    chk1("fwd_rs2_sel", id, hz.fwd_rs2_sel,         f2);
    chk1("mem_timeout", id, {1'b0, hz.mem_timeout}, {1'b0, to});
  endtask

  initial begin
    nop = '0;
    // Each row is one cycle: D inputs, E_jb, expected stall/jb/fwd (dmem_ready=1 throughout).
    tbl.push_back(vv(mk(1, 2,1, 0,0,  5,1,1,1), 0, 0,0, 0,0)); // lw x5
    tbl.push_back(vv(mk(1, 1,1, 5,1,  6,1,0,0), 0, 1,0, 0,0)); // add x6,x1,x5: load-use
    tbl.push_back(vv(mk(1, 1,1, 5,1,  6,1,0,0), 0, 0,0, 0,0)); // held: load in M, no fwd
    tbl.push_back(vv(mk(1, 6,1, 5,1,  8,1,0,0), 0, 0,0, 0,2)); // load in W
    tbl.push_back(vv(mk(1, 6,1, 8,1,  0,0,0,0), 0, 0,0, 1,0)); // add x6 in M
    tbl.push_back(vv(mk(1, 8,1, 0,0,  3,1,0,0), 0, 0,0, 1,0)); // addi x3,x8
    tbl.push_back(vv(mk(1, 3,1, 3,1,  4,1,0,0), 0, 0,0, 0,0)); // sub x4,x3,x3
    tbl.push_back(vv(mk(1, 3,1, 3,1,  9,1,0,0), 0, 0,0, 1,1)); // addi in M: both fwd M
    tbl.push_back(vv(mk(1, 3,1, 4,1,  0,0,0,0), 0, 0,0, 2,1)); // x3 from W, x4 from M
    tbl.push_back(vv(mk(1, 9,1, 0,0,  0,1,1,1), 0, 0,0, 1,0)); // lw x0
    tbl.push_back(vv(mk(1, 0,1, 0,0,  0,1,0,0), 0, 0,0, 0,0)); // addi x0,x0: no load-use on x0
    tbl.push_back(vv(mk(1, 0,1, 0,1, 11,1,0,0), 0, 0,0, 0,0));
    tbl.push_back(vv(mk(1, 0,1, 0,1,  0,0,0,0), 0, 0,0, 0,0)); // x0 writers in M and W
    tbl.push_back(vv(mk(1,11,1, 0,0, 12,1,1,1), 0, 0,0, 1,0)); // lw x12
    tbl.push_back(vv(mk(1,12,1,12,1, 13,1,0,0), 1, 0,1, 0,0)); // flush beats load-use
    tbl.push_back(vv(mk(1,12,1,12,1, 13,1,0,0), 0, 0,0, 0,0)); // E is bubble: no stall
    tbl.push_back(vv(mk(1,12,1,13,1,  0,0,0,0), 0, 0,0, 2,0));
    tbl.push_back(vv(mk(1,13,1, 0,0, 14,1,0,0), 0, 0,0, 1,0));
    tbl.push_back(vv(mk(1,13,1, 0,0, 14,1,0,0), 0, 0,0, 2,0));
    tbl.push_back(vv(mk(1,14,1, 0,0,  0,0,0,0), 0, 0,0, 1,0));
    tbl.push_back(vv(mk(1,14,1,14,1,  0,0,0,0), 0, 0,0, 1,1)); // x14 in M and W: M wins
    tbl.push_back(vv(mk(1, 0,1, 0,0, 15,1,1,1), 0, 0,0, 0,0)); // lw x15
    tbl.push_back(vv(mk(1,15,0,15,0, 16,1,0,0), 0, 0,0, 0,0)); // indices match but unused
    tbl.push_back(vv(mk(1, 0,1, 0,0, 15,1,1,1), 0, 0,0, 0,0)); // lw x15 again
    tbl.push_back(vv(mk(1,15,1, 0,0, 17,1,0,0), 0, 1,0, 2,0)); // rs1 load-use
    tbl.push_back(vv(mk(1,15,1, 0,0, 17,1,0,0), 0, 0,0, 0,0));
    tbl.push_back(vv(nop,                        0, 0,0, 0,0));
    tbl.push_back(vv(mk(1, 0,1, 0,0, 18,1,1,1), 0, 0,0, 0,0)); // lw x18
    tbl.push_back(vv(mk(0,18,1, 0,0,  0,0,0,0), 0, 0,0, 0,0)); // invalid D: no stall
    tbl.push_back(vv(nop,                        0, 0,0, 0,0));
    tbl.push_back(vv(nop,                        0, 0,0, 0,0));

    drive(nop, 1'b0, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    cyc(nop, 0, 1, 0);
    chk_all(0, 0, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      cyc(tbl[i].d, tbl[i].ejb, 1'b1, 1'b0);
      chk_all(i + 1, tbl[i].st, tbl[i].fl, 1'b0, tbl[i].f1, tbl[i].f2, 1'b0);
    end

    // Three-cycle memory wait with a load in M, a load in E and a dependent in D.
    cyc(mk(1,0,1,0,0,20,1,1,1), 0, 1, 0); chk_all(100, 0,0,0, 0,0, 0);
    cyc(mk(1,0,1,0,0,21,1,1,1), 0, 1, 0); chk_all(101, 0,0,0, 0,0, 0);
    dep = mk(1,21,1,20,1,22,1,0,0);
    for (int k = 0; k < 3; k++) begin
      cyc(dep, (k == 1), 0, 0);
      chk_all(102 + k, 0,0,1, 0,0, 0);
    end
    cyc(dep, 0, 1, 0); chk_all(105, 1,0,0, 0,0, 0);
    cyc(dep, 0, 1, 0); chk_all(106, 0,0,0, 0,2, 0);
    cyc(dep, 0, 1, 0); chk_all(107, 0,0,0, 2,0, 0);

    // Twenty-cycle wait: timeout rises on frozen cycle 15 and sticks.
    cyc(mk(1,0,1,0,0,23,1,1,1), 0, 1, 0); chk_all(108, 0,0,0, 0,0, 0);
    cyc(nop, 0, 1, 0);                    chk_all(109, 0,0,0, 0,0, 0);
    for (int k = 1; k <= 20; k++) begin
      cyc(nop, 0, 0, 0);
      chk_all(109 + k, 0,0,1, 0,0, (k >= 15));
    end
    cyc(nop, 0, 1, 0); chk_all(130, 0,0,0, 0,0, 1);

    // Reset during a load-use stall clears the shadows and the sticky flag.
    cyc(mk(1,0,1,0,0,24,1,1,1), 0, 1, 0); chk_all(131, 0,0,0, 0,0, 1);
    cyc(mk(1,24,1,0,0,25,1,0,0), 0, 1, 1); chk_all(132, 1,0,0, 0,0, 1);
    cyc(mk(1,24,1,0,0,25,1,0,0), 0, 0, 0); chk_all(133, 0,0,0, 0,0, 0);

    // Reset during a freeze overrides the hold.
    cyc(mk(1,0,1,0,0,26,1,1,1), 0, 1, 0); chk_all(134, 0,0,0, 0,0, 0);
    cyc(nop, 0, 1, 0); chk_all(135, 0,0,0, 0,0, 0);
    cyc(nop, 1, 0, 0); chk_all(136, 0,0,1, 0,0, 0);
    cyc(nop, 0, 0, 1); chk_all(137, 0,0,1, 0,0, 0);
    cyc(nop, 0, 0, 0); chk_all(138, 0,0,0, 0,0, 0);
    cyc(nop, 1, 1, 0); chk_all(139, 0,1,0, 0,0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
